// File: rtl/servo_duty_sequencer.sv
// =============================================================================
// servo_duty_sequencer: once-per-frame ADC sample capture -> servo PWM duty.
// Rev 1.0
// =============================================================================
`default_nettype none

module servo_duty_sequencer #(
  parameter int CANT_BITS   = 13,
  parameter int CNT_W       = 21,
  parameter int FRAME_TICKS = 2000000,
  parameter int BASE_TICKS  = 100000,
  parameter int STEP_TICKS  = 392,
  parameter int TIMEOUT     = 1000,
  parameter int DUTY_RST    = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_enable,
  output logic                 o_adc_start,
  input  logic [CANT_BITS-2:0] i_dato_in,
  input  logic                 i_dato_valid,
  output logic                 o_dato_ready,
  output logic                 o_pwm_out,
  output logic [CANT_BITS-1:0] o_duty_cur,
  output logic                 o_frame_tick,
  output logic                 o_err_timeout
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_CONV = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_fcnt;
  logic [CNT_W-1:0]     r_hi;
  logic [CNT_W-1:0]     w_hi_new;
  logic [CNT_W-1:0]     w_hi_cmp;
  logic [TO_W-1:0]      r_tcnt;
  logic [7:0]           r_code;
  logic [CANT_BITS-1:0] r_shadow;
  logic [CANT_BITS-1:0] r_active;
  logic [CANT_BITS-1:0] w_duty_new;
  logic                 r_pwm;
  logic                 w_frame_start;
  logic                 w_capture;
  logic                 w_load_shadow;
  logic                 w_timeout_hit;
  logic                 w_unused_lsbs;

  assign w_frame_start = i_enable && (r_fcnt == '0);
  assign o_frame_tick  = i_enable && (r_fcnt == CNT_W'(FRAME_TICKS - 1));
  assign w_hi_new      = CNT_W'(BASE_TICKS) + CNT_W'(r_shadow) * CNT_W'(STEP_TICKS);
  // On the first cycle of a frame the new high time is not registered yet.
  assign w_hi_cmp      = (r_fcnt == '0) ? w_hi_new : r_hi;
  assign w_duty_new    = CANT_BITS'(r_code);
  assign w_timeout_hit = (r_tcnt == TO_W'(TIMEOUT - 1));
  assign w_unused_lsbs = ^i_dato_in[CANT_BITS-10:0];
  assign o_pwm_out     = r_pwm;
  assign o_duty_cur    = r_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    o_adc_start   = 1'b0;
    o_dato_ready  = 1'b0;
    o_err_timeout = 1'b0;
    w_capture     = 1'b0;
    w_load_shadow = 1'b0;
    case (r_state)
      S_IDLE: if (i_enable) w_state_nxt = S_REQ;
      S_REQ: begin
        o_adc_start = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        o_dato_ready = 1'b1;
        if (i_dato_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_CONV;
        end else if (w_timeout_hit) begin
          o_err_timeout = 1'b1;
          w_state_nxt   = S_HOLD;
        end
      end
      S_CONV: begin
        w_load_shadow = 1'b1;
        w_state_nxt   = S_HOLD;
      end
      S_HOLD: if (o_frame_tick) w_state_nxt = S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
    // Stopping abandons any request or handshake in flight.
    if (!i_enable) begin
      w_state_nxt   = S_IDLE;
      o_adc_start   = 1'b0;
      o_dato_ready  = 1'b0;
      o_err_timeout = 1'b0;
      w_capture     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt   <= '0;
      r_hi     <= CNT_W'(BASE_TICKS + DUTY_RST * STEP_TICKS);
      r_active <= CANT_BITS'(DUTY_RST);
      r_shadow <= CANT_BITS'(DUTY_RST);
      r_pwm    <= 1'b0;
      r_tcnt   <= '0;
      r_code   <= '0;
    end else begin
      if (!i_enable || o_frame_tick) begin
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + CNT_W'(1);
      end
      if (w_frame_start) begin
        r_active <= r_shadow;
        r_hi     <= w_hi_new;
      end
      r_pwm <= i_enable && (r_fcnt < w_hi_cmp);
      if (r_state == S_REQ) begin
        r_tcnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_tcnt <= r_tcnt + TO_W'(1);
      end
      // Sign bit kept as plain data; bit 4 inverted rounds to the 8-bit code.
      if (w_capture) begin
        r_code <= {i_dato_in[CANT_BITS-2 -: 7], ~i_dato_in[CANT_BITS-9]};
      end
      if (w_load_shadow) begin
        r_shadow <= w_duty_new;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_servo_duty_sequencer.sv
// =============================================================================
// tb_servo_duty_sequencer: random per-frame ADC traffic against a frame-level model.
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_servo_duty_sequencer;

  localparam int FRAME = 1000;
  localparam int BASE  = 100;
  localparam int STEP  = 2;
  localparam int TMO   = 50;
  localparam int DRST  = 128;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        enable     = 1'b0;
  logic        dato_valid = 1'b0;
  logic [11:0] dato_in    = '0;
  logic        adc_start;
  logic        dato_ready;
  logic        pwm_out;
  logic [12:0] duty_cur;
  logic        frame_tick;
  logic        err_timeout;

  servo_duty_sequencer #(
    .CANT_BITS  (13),
    .CNT_W      (21),
    .FRAME_TICKS(FRAME),
    .BASE_TICKS (BASE),
    .STEP_TICKS (STEP),
    .TIMEOUT    (TMO),
    .DUTY_RST   (DRST)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (enable),
    .o_adc_start  (adc_start),
    .i_dato_in    (dato_in),
    .i_dato_valid (dato_valid),
    .o_dato_ready (dato_ready),
    .o_pwm_out    (pwm_out),
    .o_duty_cur   (duty_cur),
    .o_frame_tick (frame_tick),
    .o_err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int duty;
    int hi;
    int err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks     = 0;
  int   n_fail       = 0;
  int   model_shadow = DRST;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Position code: top eight sample bits with the least significant one flipped.
  function automatic int code_of(input logic [11:0] s);
    return (int'(s) >> 4) ^ 1;
  endfunction

  // Monitor: accumulates one frame of observations and scores it at frame_tick.
  int cyc = 0, win_len = 0, pwm_cnt = 0, adc_cnt = 0, err_cnt = 0;
  int t_adc = 0, t_exp_adc = 0;
  bit adc_ok = 1'b1, prev_en = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n || !enable) begin
      win_len = 0; pwm_cnt = 0; adc_cnt = 0; err_cnt = 0;
      adc_ok = 1'b1; prev_en = 1'b0;
    end else begin
      if (!prev_en) t_exp_adc = cyc + 1;
      prev_en = 1'b1;
      win_len++;
      if (pwm_out) pwm_cnt++;
      if (adc_start) begin
        adc_cnt++;
        t_adc = cyc;
        if (cyc != t_exp_adc) adc_ok = 1'b0;
      end
      if (err_timeout) begin
        err_cnt++;
        chk("err_latency", cyc - t_adc, TMO);
      end
      if (frame_tick) begin
        if (sb_q.size() == 0) begin
          chk("sb_expect_present", 0, 1);
        end else begin
          e = sb_q.pop_front();
          chk("frame_len", win_len, FRAME);
          chk("duty_cur", int'(duty_cur), e.duty);
          chk("pwm_high_cycles", pwm_cnt, e.hi);
          chk("err_timeout_count", err_cnt, e.err);
          chk("adc_start_count", adc_cnt, 1);
          chk("adc_start_timing", int'(adc_ok), 1);
        end
        win_len = 0; pwm_cnt = 0; adc_cnt = 0; err_cnt = 0; adc_ok = 1'b1;
        t_exp_adc = cyc + 1;
      end
    end
  end

  task automatic wait_adc(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1200 && !ok; i++) begin
      @(negedge clk);
      if (adc_start) ok = 1'b1;
    end
    chk("adc_start_seen", int'(ok), 1);
  endtask

  // mode 0: ADC stays silent; mode 1: one-cycle valid d cycles after adc_start.
  task automatic run_frame(input int mode, input logic [11:0] smp, input int d);
    bit   ok;
    bit   cap;
    exp_t e;
    wait_adc(ok);
    if (!ok) return;
    cap    = (mode == 1) && (d >= 1) && (d <= TMO);
    e.duty = model_shadow;
    e.hi   = BASE + STEP * model_shadow;
    e.err  = cap ? 0 : 1;
    sb_q.push_back(e);
    if (mode == 1) begin
      repeat (d) @(posedge clk);
      #1;
      dato_in    = smp;
      dato_valid = 1'b1;
      chk("dato_ready", int'(dato_ready), cap ? 1 : 0);
      @(posedge clk);
      #1;
      dato_valid = 1'b0;
      dato_in    = 12'($urandom);
      if (cap) model_shadow = code_of(smp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_duty_cur"}, int'(duty_cur), DRST);
    chk({tag, "_pwm_out"}, int'(pwm_out), 0);
    chk({tag, "_adc_start"}, int'(adc_start), 0);
    chk({tag, "_dato_ready"}, int'(dato_ready), 0);
    chk({tag, "_frame_tick"}, int'(frame_tick), 0);
    chk({tag, "_err_timeout"}, int'(err_timeout), 0);
  endtask

  initial begin
    bit ok;
    int stray;
    int mode;
    int d;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    enable = 1'b1;

    run_frame(0, 12'h000, 0);      // no response: 356-cycle pulse, timeout
    run_frame(1, 12'h7F0, 10);     // shadow -> 126
    run_frame(1, 12'h000, 5);      // duty 126 this frame; shadow -> 1
    run_frame(1, 12'hFE0, 20);     // duty 1; shadow -> 255
    run_frame(1, 12'h7F0, 120);    // valid lands in HOLD, dropped
    run_frame(1, 12'($urandom), TMO);  // valid on the expiry cycle wins

    for (int i = 0; i < 16; i++) begin
      mode = int'($urandom_range(0, 1));
      d    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TMO + 1, 400))
                                         : int'($urandom_range(1, TMO));
      run_frame(mode, 12'($urandom), d);
    end

    // Drop enable while the pulse is high at fcnt=40.
    wait_adc(ok);
    repeat (40) @(posedge clk);
    #1;
    enable = 1'b0;
    @(negedge clk);
    chk("pwm_before_drop", int'(pwm_out), 1);
    @(negedge clk);
    chk("pwm_after_drop", int'(pwm_out), 0);
    chk("ready_after_drop", int'(dato_ready), 0);
    chk("duty_retained", int'(duty_cur), model_shadow);
    @(posedge clk);
    #1;
    dato_in    = 12'h000;
    dato_valid = 1'b1;
    @(posedge clk);
    #1;
    dato_valid = 1'b0;
    stray = 0;
    repeat (60) begin
      @(negedge clk);
      if (adc_start || err_timeout || pwm_out || dato_ready || frame_tick) stray++;
    end
    chk("disabled_quiet", stray, 0);
    chk("duty_retained_idle", int'(duty_cur), model_shadow);
    @(posedge clk);
    #1;
    enable = 1'b1;
    run_frame(1, 12'($urandom), int'($urandom_range(1, TMO)));
    run_frame(1, 12'h000, 3);      // shadow -> 1 so reset has something to undo

    // Asynchronous reset in WAIT with a sample being offered.
    wait_adc(ok);
    repeat (5) @(posedge clk);
    #1;
    dato_in    = 12'h7F0;
    dato_valid = 1'b1;
    rst_n      = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    enable     = 1'b0;
    dato_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n        = 1'b1;
    model_shadow = DRST;
    @(negedge clk);
    chk("duty_after_release", int'(duty_cur), DRST);
    @(posedge clk);
    #1;
    enable = 1'b1;
    run_frame(0, 12'h000, 0);
    run_frame(1, 12'($urandom), int'($urandom_range(1, TMO)));

    for (int i = 0; i < 1500 && sb_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
